// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word size, address check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCEPT = 2'b01,
      WAIT   = 2'b10,
      RESP   = 2'b11
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

   // True when the access is not word aligned or falls past the end of storage.
   // The limit is formed in 34 bits so large depths cannot wrap the compare.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
      logic [33:0] limit;
      limit = 34'(depth_words) * 34'(WORD_BYTES);
      return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM behind the responder: single port, synchronous write, asynchronous read.
// Latency: read data is combinational from addr; a write lands on the rising edge.
// Backpressure: none; the caller owns sequencing.
// Ports: clk, we (write enable), addr (word index), wdata (write word), rdata (read word).
module dmem_array #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   // Contents are deliberately not reset; they are undefined after power-up.
   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: latches a load/store, inserts WAIT_CYCLES wait states, answers with a one-cycle ready.
// Latency: request seen in IDLE at cycle n -> MemReadyM at n+WAIT_CYCLES+2 (errors pay the same latency).
// Backpressure: MemStallM = MemReqM & (state != RESP), combinational so the pipeline holds in the request cycle.
// Ports: clk, reset (async, active low); request MemReqM/MemWriteM/AddrM/WriteDataM;
//        response ReadDataM (0 unless a good load is ready), MemReadyM, MemStallM, MemErrM.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemReadyM,
   output logic        MemStallM,
   output logic        MemErrM
);

   localparam int AW     = $clog2(DEPTH_WORDS);
   localparam int WCNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_CYCLES);

   state_t              state_q,     state_d;
   logic [WCNT_W-1:0]   wcnt_q,      wcnt_d;
   logic                req_write_q, req_write_d;
   logic [31:0]         req_addr_q,  req_addr_d;
   logic [31:0]         req_wdata_q, req_wdata_d;

   logic                acc_err;
   logic                in_resp;
   logic                mem_we;
   logic [31:0]         mem_rdata;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      case (state_q)
         IDLE: begin
            // The request is captured once; the inputs are ignored until the next IDLE.
            if (MemReqM) begin
               req_write_d = MemWriteM;
               req_addr_d  = AddrM;
               req_wdata_d = WriteDataM;
               state_d     = ACCEPT;
            end
         end
         ACCEPT: begin
            wcnt_d  = WCNT_INIT;
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
         end
         WAIT: begin
            // Saturate at zero so the counter can never wrap.
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
            if (wcnt_q == WCNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wcnt_q      <= '0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
      end
   end

   // Error is judged on the latched address so it is stable for the whole transaction.
   assign acc_err = addr_err(req_addr_q, DEPTH_WORDS);
   assign in_resp = (state_q == RESP);
   // Store commits at the end of RESP, and never for a faulting access.
   assign mem_we  = in_resp & req_write_q & ~acc_err;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (req_addr_q[AW+1:2]),
      .wdata (req_wdata_q),
      .rdata (mem_rdata)
   );

   assign MemReadyM = in_resp;
   assign MemErrM   = in_resp & acc_err;
   assign ReadDataM = (in_resp & ~req_write_q & ~acc_err) ? mem_rdata : 32'h0;
   // Reset gates the request term so the stall drops the moment reset asserts.
   assign MemStallM = reset & MemReqM & ~in_resp;

   // The hazard unit must keep the request up until the RESP cycle retires it.
   a_req_held: assert property (@(posedge clk) disable iff (!reset)
                                (state_q != IDLE) |-> MemReqM);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int W0 = 2;
   localparam int W1 = 0;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        req_i  [2];
   logic        wr_i   [2];
   logic [31:0] addr_i [2];
   logic [31:0] wd_i   [2];
   logic [31:0] rd_o   [2];
   logic        rdy_o  [2];
   logic        stl_o  [2];
   logic        err_o  [2];

   int cyc   = 0;
   int npass = 0;
   int ntot  = 0;
   int mon_idx;

   typedef struct {
      int          sel;
      int          due;
      logic        is_load;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   typedef struct {
      int          sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      logic        b2b;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .reset(reset), .MemReqM(req_i[0]), .MemWriteM(wr_i[0]), .AddrM(addr_i[0]),
      .WriteDataM(wd_i[0]), .ReadDataM(rd_o[0]), .MemReadyM(rdy_o[0]), .MemStallM(stl_o[0]),
      .MemErrM(err_o[0]));

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .reset(reset), .MemReqM(req_i[1]), .MemWriteM(wr_i[1]), .AddrM(addr_i[1]),
      .WriteDataM(wd_i[1]), .ReadDataM(rd_o[1]), .MemReadyM(rdy_o[1]), .MemStallM(stl_o[1]),
      .MemErrM(err_o[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic vec_t mk(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic err, input logic [31:0] rd, input logic b2b);
      vec_t v;
      v.sel = s; v.wr = wr; v.addr = addr; v.wd = wd; v.err = err; v.rd = rd; v.b2b = b2b;
      return v;
   endfunction

   // Response monitor: every cycle, ready must match the scoreboard's due cycle.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         mon_idx = -1;
         foreach (sb[k]) if (sb[k].sel == s && sb[k].due == cyc) mon_idx = k;
         chk($sformatf("ready[%0d]", s), 32'(rdy_o[s]), 32'(mon_idx >= 0));
         if (mon_idx >= 0) begin
            chk($sformatf("err[%0d]", s), 32'(err_o[s]), 32'(sb[mon_idx].err));
            if (sb[mon_idx].is_load) chk($sformatf("rdata[%0d]", s), rd_o[s], sb[mon_idx].rd);
            sb.delete(mon_idx);
         end else begin
            chk($sformatf("err_quiet[%0d]", s), 32'(err_o[s]), 32'h0);
            chk($sformatf("rdata_quiet[%0d]", s), rd_o[s], 32'h0);
         end
      end
   end

   // Starts at posedge+1 in IDLE; returns at posedge+1 of the IDLE cycle after RESP with req low.
   task automatic txn(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input logic scramble);
      int   w;
      exp_t e;
      w = (s == 0) ? W0 : W1;
      req_i[s] = 1'b1; wr_i[s] = wr; addr_i[s] = addr; wd_i[s] = wd;
      e.sel = s; e.due = cyc + w + 2; e.is_load = !wr; e.err = err; e.rd = rd;
      sb.push_back(e);
      for (int i = 0; i <= w + 2; i++) begin
         @(negedge clk);
         chk($sformatf("stall[%0d] n+%0d", s, i), 32'(stl_o[s]), 32'(i <= w + 1));
         if (scramble && i == 1) begin
            wr_i[s] = ~wr; addr_i[s] = ~addr; wd_i[s] = ~wd;
         end
      end
      @(posedge clk); #1;
      req_i[s] = 1'b0;
   endtask

   task automatic idle(input int s);
      @(negedge clk);
      chk($sformatf("idle_stall[%0d]", s), 32'(stl_o[s]), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         req_i[s] = 1'b0; wr_i[s] = 1'b0; addr_i[s] = '0; wd_i[s] = '0;
      end

      vecs.push_back(mk(0, 1'b1, 32'h20,       32'hA5A5A5A5, 1'b0, 32'h0,        1'b1));
      vecs.push_back(mk(0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0));
      vecs.push_back(mk(0, 1'b1, 32'h4,        32'h11112222, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b1, 32'h6,        32'hFFFFFFFF, 1'b1, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b0, 32'h4,        32'h0,        1'b0, 32'h11112222, 1'b1));
      vecs.push_back(mk(0, 1'b0, 32'h400,      32'h0,        1'b1, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b1, 32'h8,        32'hA0A0A0A0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b1, 32'hC,        32'h0C0C0C0C, 1'b0, 32'h0,        1'b1));
      vecs.push_back(mk(0, 1'b0, 32'h8,        32'h0,        1'b0, 32'hA0A0A0A0, 1'b0));
      vecs.push_back(mk(0, 1'b0, 32'hC,        32'h0,        1'b0, 32'h0C0C0C0C, 1'b1));
      vecs.push_back(mk(0, 1'b1, 32'h3FC,      32'h77777777, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b0, 32'h3FC,      32'h0,        1'b0, 32'h77777777, 1'b0));
      vecs.push_back(mk(0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0,        1'b0));
      vecs.push_back(mk(0, 1'b0, 32'h3FE,      32'h0,        1'b1, 32'h0,        1'b1));
      vecs.push_back(mk(1, 1'b1, 32'h0,        32'h12345678, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h12345678, 1'b0));
      vecs.push_back(mk(1, 1'b0, 32'h1,        32'h0,        1'b1, 32'h0,        1'b1));
      vecs.push_back(mk(1, 1'b1, 32'h3FD,      32'hCAFEF00D, 1'b1, 32'h0,        1'b0));

      #2 reset = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_ready[%0d]", s), 32'(rdy_o[s]), 32'h0);
         chk($sformatf("rst_stall[%0d]", s), 32'(stl_o[s]), 32'h0);
         chk($sformatf("rst_err[%0d]", s),   32'(err_o[s]), 32'h0);
         chk($sformatf("rst_rdata[%0d]", s), rd_o[s],       32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b1;

      // First vector starts immediately: accepted on the first edge after release.
      foreach (vecs[k]) begin
         if (!vecs[k].b2b) idle(vecs[k].sel);
         txn(vecs[k].sel, vecs[k].wr, vecs[k].addr, vecs[k].wd, vecs[k].err, vecs[k].rd, 1'b0);
      end

      // Inputs changed after acceptance must not affect the transaction.
      idle(0);
      txn(0, 1'b1, 32'h30, 32'h55AA55AA, 1'b0, 32'h0, 1'b1);
      idle(0);
      txn(0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h55AA55AA, 1'b0);

      // Reset during WAIT of a store to 0x20: outputs drop at once, store is lost.
      idle(0);
      req_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 32'h20; wd_i[0] = 32'h0BADF00D;
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid_stall_before_reset", 32'(stl_o[0]), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(rdy_o[0]), 32'h0);
      chk("mid_rst_stall", 32'(stl_o[0]), 32'h0);
      chk("mid_rst_err",   32'(err_o[0]), 32'h0);
      chk("mid_rst_rdata", rd_o[0],       32'h0);
      req_i[0] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
      idle(0);
      idle(1);

      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, ntot);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined MIPS core. It serves the M-stage load/store requests issued by the pipeline control (MemtoRegM / MemWriteM) and inserts a programmable number of wait states. While a request is in flight it drives a stall back into the hazard logic, and it returns read data or commits the write on a single-cycle ready pulse.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words of storage; power of two, at least 2.
- WAIT_CYCLES, 2: extra wait states per access; range 0..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReqM  in  1  M-stage memory access request (MemtoRegM | MemWriteM).
- MemWriteM  in  1  1 = store, 0 = load; valid while MemReqM = 1.
- AddrM  in  32  byte address (ALUOutM).
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data; valid only while MemReadyM = 1, otherwise 0.
- MemReadyM  out  1  one-cycle completion pulse.
- MemStallM  out  1  hold F/D/E/M stages and bubble W.
- MemErrM  out  1  misaligned or out-of-range access; asserted together with MemReadyM.

## Operation
State machine states: IDLE, ACCEPT, WAIT, RESP.
- IDLE: if MemReqM = 1, latch MemWriteM, AddrM, and WriteDataM, then go to ACCEPT. Otherwise stay in IDLE.
- ACCEPT: load wcnt with WAIT_CYCLES. Go to RESP if WAIT_CYCLES = 0, otherwise go to WAIT.
- WAIT: decrement wcnt each cycle. Go to RESP on the cycle wcnt = 1.
- RESP: MemReadyM = 1. For a load, ReadDataM = mem[addr[log2(DEPTH_WORDS)+1:2]]. For a store, the write commits at the end of this cycle. Always go to IDLE next.
- MemStallM = MemReqM & (state != RESP).
  - In IDLE with a request present, stall is asserted combinationally, so the pipeline holds that same cycle.
- Error condition: AddrM[1:0] != 0 or AddrM >= 4*DEPTH_WORDS. It is evaluated on the latched address.
  - On error, RESP also asserts MemErrM, ReadDataM = 0, and no store commits.
  - Error requests pay the full latency, with no early exit.
- Latched request fields are used for the whole transaction. Changes on the request inputs after IDLE are ignored until the next IDLE.
- wcnt width is max(1, $clog2(WAIT_CYCLES+1)) bits and never wraps below 0.
- Storage is not cleared by reset, and its contents after power-up are undefined.

## Timing
- Request seen in IDLE at cycle n. MemReadyM is high in cycle n+WAIT_CYCLES+2. MemStallM is high for WAIT_CYCLES+2 cycles, n through n+WAIT_CYCLES+1.
- Store data becomes visible to a load accepted at cycle n+WAIT_CYCLES+3 or later.
- Back-to-back requests: RESP is followed by IDLE, which samples the next M-stage instruction. Minimum spacing is one IDLE cycle between transactions.
- MemReqM low in IDLE: all outputs 0 and the state holds.
- Requirement on the hazard unit: MemReqM low while a transaction is active (pipeline flushed or bubbled) is illegal. An assertion flags it, and the FSM still completes the transaction.
- Reset asserted at any time, including mid-transaction:
  - state = IDLE, wcnt = 0, and latched request registers = 0.
  - Outputs immediately 0: ReadDataM = 0, MemReadyM = 0, MemStallM = 0 (its MemReqM term is gated by reset), MemErrM = 0.
  - Any pending store is dropped.
- Reset release: the first request can be accepted on the first rising edge after deassertion.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, ACCEPT, WAIT, RESP), 2-bit encoding 00/01/10/11;
  - the WORD_BYTES = 4 constant;
  - the address-check function (misaligned or out-of-range).
- One natural sub-module: dmem_array, a single-port synchronous-write, asynchronous-read word RAM parameterized by DEPTH_WORDS. The FSM, wait counter, request latch, and error logic live in dmem_responder.

## Test plan
- WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 at cycle 5:
  - MemStallM is high for cycles 5–8 and MemReadyM pulses at cycle 9.
  - A load from 0x10 issued at cycle 10 returns 0xDEADBEEF with MemReadyM at cycle 14.
- WAIT_CYCLES=0, load from 0x0 after a store of 0x12345678: stall lasts 2 cycles, ready at n+2, ReadDataM = 0x12345678.
- Misaligned store to 0x6, then load 0x4: MemErrM and MemReadyM are high together, and the load returns the old value of 0x4 (no write happened).
- Out-of-range load 0x400 with DEPTH_WORDS=256: MemErrM = 1, ReadDataM = 0, latency unchanged.
- Back-to-back loads 0x8 and 0xC: the second request is accepted in the IDLE cycle right after RESP, and both return correct data.
- reset pulsed low during WAIT of a store to 0x20:
  - All outputs go to 0 immediately.
  - A subsequent load of 0x20 returns the pre-store value.
  - The FSM restarts from IDLE.
